frame_arbiter: RTL and testbench
================================

FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 The block SHALL have parameter FRAMELEN, default 16, meaning bytes per frame; legal values are powers of two, 2 to 256.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the limit of stalled cycles before a frame is aborted.
REQ-003 clk  in  1  system clock; the block SHALL use this single clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 SrcAvail  in  2  bit n high means source n holds at least one committed frame.
REQ-006 Src0Val  in  8  byte from source 0.
REQ-007 Src0Ready  in  1  source 0 byte valid, one-cycle pulse.
REQ-008 Src0Next  out  1  request to source 0 for its next byte.
REQ-009 Src1Val  in  8  byte from source 1.
REQ-010 Src1Ready  in  1  source 1 byte valid, one-cycle pulse.
REQ-011 Src1Next  out  1  request to source 1 for its next byte.
REQ-012 OutNext  in  1  downstream (serial/USB) request for the next byte.
REQ-013 OutVal  out  8  forwarded byte.
REQ-014 OutReady  out  1  OutVal valid, one-cycle pulse.
REQ-015 OutSrc  out  1  source id of the current OutVal.
REQ-016 OutFirst  out  1  high with OutReady on the first byte of a frame.
REQ-017 Grant  out  2  one-hot current owner; 00 means none.
REQ-018 Timeout  out  1  one-cycle pulse on frame abort.

Function
REQ-019 The state machine SHALL have three states: IDLE, ARB and XFER.
REQ-020 IDLE: when SrcAvail is not 00, the block SHALL go to ARB on the next cycle.
REQ-021 ARB: the block SHALL pick a source round-robin and go to XFER on the next cycle.
  - Priority goes to the source other than lastServed.
  - If only one source is available, that source is granted.
  - If none is available by then, the block returns to IDLE.
REQ-022 The block SHALL hold Grant constant for the whole of XFER.
REQ-023 In XFER, SrcNNext SHALL equal OutNext AND Grant[N], combinationally; the non-granted SrcNext SHALL be 0.
REQ-024 The granted source's Ready/Val SHALL be registered onto OutReady/OutVal/OutSrc with 1-cycle latency.
REQ-025 Ready from a non-granted source SHALL be ignored.
REQ-026 The byte counter (log2 FRAMELEN bits) SHALL behave as follows:
  - cleared on entry to XFER;
  - incremented on each granted Ready;
  - OutFirst asserted when the counter is 0 at that Ready.
REQ-027 On the granted Ready with counter == FRAMELEN-1, the block SHALL:
  - update lastServed;
  - clear Grant;
  - go to ARB on the next cycle; the counter wraps to 0.
REQ-028 The stall counter SHALL:
  - increment each XFER cycle with OutNext high and no granted Ready;
  - clear on a granted Ready;
  - hold while OutNext is low.
REQ-029 When the stall counter reaches TIMEOUT, the block SHALL:
  - pulse Timeout;
  - update lastServed to the stalled source;
  - clear Grant;
  - go to IDLE.
  No partial-frame padding is emitted.
REQ-030 A SrcAvail change during XFER SHALL be ignored until frame end or abort.
REQ-031 OutNext low mid-frame SHALL pause the transfer; the byte count is held and the grant is kept.
REQ-032 A granted Ready on the same cycle the stall counter would reach TIMEOUT SHALL take precedence, and no abort occurs.

Reset
REQ-033 On rst, the block SHALL set:
  - state=IDLE, Grant=00, lastServed=1 (so source 0 wins first), counters=0;
  - OutVal=0, OutReady=0, OutSrc=0, OutFirst=0, Timeout=0;
  - Src0Next=0, Src1Next=0.
REQ-034 Reset mid-frame SHALL abandon the frame immediately, with no Timeout pulse.

Structure
REQ-035 The state enumeration and default FRAMELEN/TIMEOUT constants SHALL live in the shared orbtrace package.
REQ-036 The stall counter and its compare SHALL be one sub-module, frame_watchdog (inputs: clear, count-enable; output: expired).

Verification
REQ-037 The bench SHALL cover each scenario below with the stated response.
  - Reset, SrcAvail=11, OutNext held high, both sources answering within 2 cycles -> 16 bytes with OutSrc=0, then 16 with OutSrc=1, then 0 again; OutFirst on bytes 0, 16, 32.
  - SrcAvail=10 only -> Grant=10 within 2 cycles of leaving IDLE; Src0Next stays 0 throughout.
  - Source 0 stops answering after byte 5, OutNext high -> Timeout pulse exactly 1024 cycles after the last Ready; Grant=00; next frame granted to source 1 if available.
  - OutNext dropped for 2000 cycles mid-frame -> no Timeout; the frame resumes at byte 6 when OutNext returns.
  - Src1Ready pulsed while source 0 is granted -> no OutReady generated for it.
  - rst asserted asynchronously at byte 9 -> all outputs 0 within the reset cycle; after release, source 0 is granted first.

Source files
------------

// File: rtl/orbtrace_pkg.sv
// Shared orbtrace types and defaults: arbiter state encoding, frame/timeout defaults
// and the round-robin pick used by the frame arbiter.
package orbtrace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } arbState_t;

  localparam int FRAMELEN_DEFAULT = 16;
  localparam int TIMEOUT_DEFAULT  = 1024;

  // One-hot owner for the next frame; the source not served last wins a tie.
  function automatic logic [1:0] pickSource(input logic [1:0] avail, input logic lastServed);
    logic [1:0] pick;
    case (avail)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = lastServed ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Stall counter for the frame arbiter: counts enabled cycles since the last clear and
// flags expiry on the cycle that would bring the count to TIMEOUT.
module frame_watchdog
  import orbtrace_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic countEn,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stallCnt;

  // Expiry is gated by countEn, so a granted byte on the limit cycle always wins.
  assign expired = countEn && (stallCnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (clear || expired) begin
      stallCnt <= '0;
    end else if (countEn) begin
      stallCnt <= stallCnt + CW'(1);
    end
  end

endmodule

// File: rtl/frame_arbiter.sv
// Two-source frame arbiter: grants whole frames round-robin, forwards bytes with one
// cycle of latency and aborts a frame whose owner stalls for TIMEOUT requested cycles.
//
//   state | meaning
//   IDLE  | no frame pending, Grant=00
//   ARB   | choose next owner from SrcAvail, or fall back to IDLE
//   XFER  | frame in progress, Grant held, bytes forwarded
module frame_arbiter
  import orbtrace_pkg::*;
#(
  parameter int FRAMELEN = FRAMELEN_DEFAULT,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] SrcAvail,
  input  logic [7:0] Src0Val,
  input  logic       Src0Ready,
  output logic       Src0Next,
  input  logic [7:0] Src1Val,
  input  logic       Src1Ready,
  output logic       Src1Next,
  input  logic       OutNext,
  output logic [7:0] OutVal,
  output logic       OutReady,
  output logic       OutSrc,
  output logic       OutFirst,
  output logic [1:0] Grant,
  output logic       Timeout
);

  localparam int BW = (FRAMELEN > 1) ? $clog2(FRAMELEN) : 1;

  arbState_t state, nextState;
  logic [1:0]    grantNext;
  logic          lastServed, lastServedNext;
  logic [BW-1:0] byteCnt, byteCntNext;

  logic       inXfer;
  logic       grantedReady;
  logic [7:0] grantedVal;
  logic       frameEnd;
  logic       stallEn;
  logic       wdClear;
  logic       expired;

  assign inXfer       = (state == XFER);
  assign grantedReady = inXfer && ((Grant[0] && Src0Ready) || (Grant[1] && Src1Ready));
  assign grantedVal   = Grant[1] ? Src1Val : Src0Val;
  assign frameEnd     = grantedReady && (byteCnt == BW'(FRAMELEN - 1));
  assign stallEn      = inXfer && OutNext && !grantedReady;
  assign wdClear      = !inXfer || grantedReady;

  assign Src0Next = inXfer && OutNext && Grant[0];
  assign Src1Next = inXfer && OutNext && Grant[1];

  frame_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wdClear),
    .countEn(stallEn),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      Grant      <= 2'b00;
      lastServed <= 1'b1;
      byteCnt    <= '0;
    end else begin
      state      <= nextState;
      Grant      <= grantNext;
      lastServed <= lastServedNext;
      byteCnt    <= byteCntNext;
    end
  end

  always_comb begin
    nextState      = state;
    grantNext      = Grant;
    lastServedNext = lastServed;
    byteCntNext    = byteCnt;
    case (state)
      IDLE: begin
        if (SrcAvail != 2'b00) nextState = ARB;
      end
      ARB: begin
        byteCntNext = '0;
        grantNext   = pickSource(SrcAvail, lastServed);
        nextState   = (grantNext != 2'b00) ? XFER : IDLE;
      end
      XFER: begin
        if (grantedReady) begin
          byteCntNext = byteCnt + BW'(1);
          if (frameEnd) begin
            lastServedNext = Grant[1];
            grantNext      = 2'b00;
            nextState      = ARB;
          end
        end else if (expired) begin
          lastServedNext = Grant[1];
          grantNext      = 2'b00;
          nextState      = IDLE;
        end
      end
      default: begin
        grantNext = 2'b00;
        nextState = IDLE;
      end
    endcase
  end

  // OutVal/OutSrc keep the last forwarded byte between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OutVal   <= 8'h00;
      OutReady <= 1'b0;
      OutSrc   <= 1'b0;
      OutFirst <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      OutReady <= grantedReady;
      OutFirst <= grantedReady && (byteCnt == '0);
      Timeout  <= expired;
      if (grantedReady) begin
        OutVal <= grantedVal;
        OutSrc <= Grant[1];
      end
    end
  end

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter: responsive source models feed a scoreboard,
// a monitor pops it on every OutReady, and the main sequence walks the scenarios.
module tb_frame_arbiter;

  localparam int FL = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] SrcAvail = 2'b00;
  logic [7:0] Src0Val = 8'h00, Src1Val = 8'h00;
  logic       Src0Ready = 1'b0, Src1Ready = 1'b0;
  logic       OutNext = 1'b0;
  logic       Src0Next, Src1Next, OutReady, OutSrc, OutFirst, Timeout;
  logic [7:0] OutVal;
  logic [1:0] Grant;

  typedef struct packed {
    logic [7:0] val;
    logic       src;
    logic       first;
  } beat_t;

  beat_t sb[$];
  logic  obsSrc[$];
  logic  obsFirst[$];

  int errors = 0, checks = 0;
  int outCount = 0, timeoutCount = 0, cyc = 0, lastOutCyc = 0, toCyc = 0, modelByte = 0;
  int src0Left = 0, src1Left = 0;
  bit src1Manual = 1'b0, src0NextSeen = 1'b0;
  logic [6:0] seq0 = '0, seq1 = '0;

  always #5 clk = ~clk;

  frame_arbiter dut (
    .clk(clk), .rst(rst), .SrcAvail(SrcAvail),
    .Src0Val(Src0Val), .Src0Ready(Src0Ready), .Src0Next(Src0Next),
    .Src1Val(Src1Val), .Src1Ready(Src1Ready), .Src1Next(Src1Next),
    .OutNext(OutNext), .OutVal(OutVal), .OutReady(OutReady), .OutSrc(OutSrc),
    .OutFirst(OutFirst), .Grant(Grant), .Timeout(Timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushBeat(input logic [7:0] v, input logic s);
    beat_t b;
    b.val   = v;
    b.src   = s;
    b.first = ((modelByte % FL) == 0);
    sb.push_back(b);
    modelByte++;
  endtask

  task automatic waitOut(input string tag, input int target, input int budget);
    int k = 0;
    while (outCount < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(outCount >= target), 32'd1);
  endtask

  task automatic waitTimeout(input string tag, input int target, input int budget);
    int k = 0;
    while (timeoutCount < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(timeoutCount >= target), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "Grant"},    32'(Grant),    32'd0);
    check({tag, "OutReady"}, 32'(OutReady), 32'd0);
    check({tag, "OutVal"},   32'(OutVal),   32'd0);
    check({tag, "OutSrc"},   32'(OutSrc),   32'd0);
    check({tag, "OutFirst"}, 32'(OutFirst), 32'd0);
    check({tag, "Timeout"},  32'(Timeout),  32'd0);
    check({tag, "Src0Next"}, 32'(Src0Next), 32'd0);
    check({tag, "Src1Next"}, 32'(Src1Next), 32'd0);
  endtask

  initial forever @(posedge clk) cyc++;

  // Sources answer a request one cycle later, at most every other cycle.
  initial forever begin
    @(negedge clk);
    if (Src0Ready) begin
      Src0Ready = 1'b0;
    end else if (Src0Next && src0Left != 0) begin
      Src0Val   = {1'b0, seq0};
      seq0++;
      Src0Ready = 1'b1;
      if (src0Left > 0) src0Left--;
      pushBeat(Src0Val, 1'b0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!src1Manual) begin
      if (Src1Ready) begin
        Src1Ready = 1'b0;
      end else if (Src1Next && src1Left != 0) begin
        Src1Val   = {1'b1, seq1};
        seq1++;
        Src1Ready = 1'b1;
        if (src1Left > 0) src1Left--;
        pushBeat(Src1Val, 1'b1);
      end
    end
  end

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (Src0Next) src0NextSeen = 1'b1;
      if (Timeout) begin
        timeoutCount++;
        toCyc = cyc;
      end
      if (OutReady) begin
        obsSrc.push_back(OutSrc);
        obsFirst.push_back(OutFirst);
        outCount++;
        lastOutCyc = cyc;
        if (sb.size() == 0) begin
          check("unexpectedOutReady", 32'(OutReady), 32'd0);
        end else begin
          e = sb.pop_front();
          check("beat", {22'd0, OutVal, OutSrc, OutFirst}, {22'd0, e});
        end
      end
    end
  end

  initial begin : main
    int base, toBase;

    repeat (3) @(negedge clk);
    checkAllZero("rst_");
    rst = 1'b0;

    // Both sources available: frames alternate 0,1,0 starting with source 0.
    src0Left = -1; src1Left = -1; OutNext = 1'b1; SrcAvail = 2'b11;
    base = outCount;
    waitOut("s1wait", base + 48, 400);
    for (int i = 0; i < 48; i++) begin
      check($sformatf("s1src%0d", i),   32'(obsSrc[base + i]),   32'((i / FL) % 2));
      check($sformatf("s1first%0d", i), 32'(obsFirst[base + i]), 32'((i % FL) == 0));
    end
    src0Left = 0; src1Left = 0; SrcAvail = 2'b00;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete(); modelByte = 0;
    rst = 1'b0;

    // Only source 1 available.
    src0Left = -1; src1Left = -1; src0NextSeen = 1'b0; SrcAvail = 2'b10;
    base = outCount;
    @(negedge clk); @(negedge clk);
    check("s2grant", 32'(Grant), 32'd2);
    SrcAvail = 2'b00;
    waitOut("s2wait", base + FL, 200);
    check("s2src", 32'(obsSrc[base]), 32'd1);
    repeat (4) @(negedge clk);
    check("s2src0Next", 32'(src0NextSeen), 32'd0);
    check("s2idle", 32'(Grant), 32'd0);
    src0Left = 0; src1Left = 0;

    // Source 0 stalls after byte 5; abort then source 1 gets the next frame.
    src0Left = 6; src1Left = -1; SrcAvail = 2'b11;
    base = outCount; toBase = timeoutCount;
    waitOut("s3bytes", base + 6, 100);
    waitTimeout("s3wait", toBase + 1, 1200);
    modelByte = 0;
    check("s3delta", 32'(toCyc - lastOutCyc), 32'd1024);
    check("s3grantCleared", 32'(Grant), 32'd0);
    while (cyc < toCyc + 2) @(negedge clk);
    check("s3nextGrant", 32'(Grant), 32'd2);
    SrcAvail = 2'b00;
    waitOut("s3frame1", base + 6 + FL, 200);
    check("s3src1", 32'(obsSrc[base + 6]), 32'd1);
    check("s3first1", 32'(obsFirst[base + 6]), 32'd1);
    repeat (4) @(negedge clk);
    check("s3single", 32'(timeoutCount), 32'(toBase + 1));
    src1Left = 0;

    // Downstream pause mid-frame outlasts the stall limit without aborting.
    src0Left = 6; SrcAvail = 2'b11; OutNext = 1'b1;
    base = outCount; toBase = timeoutCount;
    waitOut("s4bytes", base + 6, 100);
    OutNext = 1'b0; SrcAvail = 2'b00;
    @(negedge clk);
    src0Left = -1;
    repeat (2000) @(negedge clk);
    check("s4noTimeout", 32'(timeoutCount), 32'(toBase));
    check("s4grantHeld", 32'(Grant), 32'd1);
    check("s4paused", 32'(outCount), 32'(base + 6));
    OutNext = 1'b1;
    waitOut("s4resume", base + FL, 100);
    check("s4byte6First", 32'(obsFirst[base + 6]), 32'd0);
    check("s4byte6Src", 32'(obsSrc[base + 6]), 32'd0);
    repeat (6) @(negedge clk);
    check("s4frameLen", 32'(outCount), 32'(base + FL));
    check("s4idle", 32'(Grant), 32'd0);
    src0Left = 0;

    // Stray Ready from the non-granted source must be dropped.
    src0Left = -1; src1Manual = 1'b1; SrcAvail = 2'b01;
    base = outCount;
    waitOut("s5start", base + 3, 100);
    SrcAvail = 2'b00;
    Src1Val = 8'hEE; Src1Ready = 1'b1;
    @(negedge clk);
    Src1Ready = 1'b0;
    @(negedge clk);
    Src1Ready = 1'b1;
    @(negedge clk);
    Src1Ready = 1'b0; Src1Val = 8'h00;
    waitOut("s5frame", base + FL, 100);
    repeat (6) @(negedge clk);
    check("s5count", 32'(outCount), 32'(base + FL));
    for (int i = 0; i < FL; i++)
      check($sformatf("s5src%0d", i), 32'(obsSrc[base + i]), 32'd0);
    src1Manual = 1'b0; src0Left = 0;

    // Asynchronous reset at byte 9 of a frame.
    src0Left = -1; src1Left = -1; SrcAvail = 2'b11;
    base = outCount; toBase = timeoutCount;
    waitOut("s6bytes", base + 10, 100);
    #2 rst = 1'b1;
    #1 checkAllZero("s6_");
    sb.delete(); modelByte = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("s6grant", 32'(Grant), 32'd1);
    SrcAvail = 2'b00;
    base = outCount;
    waitOut("s6frame", base + FL, 100);
    check("s6src", 32'(obsSrc[base]), 32'd0);
    check("s6first", 32'(obsFirst[base]), 32'd1);
    repeat (6) @(negedge clk);
    check("s6noTimeout", 32'(timeoutCount), 32'(toBase));
    check("s6idle", 32'(Grant), 32'd0);
    check("sbEmpty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
